dmem_arbiter: RTL and testbench

- Two-port arbiter/sequencer in front of the single-ported, byte-addressed, big-endian 256-byte data memory (DMEM).
- Port 0 is the CPU load/store stage. Port 1 is the debug/loader port, which preloads and dumps data memory.
- Grants one word access at a time, round-robin, with a req/done handshake.
- Holds the DMEM control, address and data stable for a full clock so the negedge write and the address-triggered read settle. Rejects misaligned or out-of-range addresses without touching memory.

---
 rtl/dmem_arbiter_pkg.sv | 27 ++
 rtl/dmem_rr_pick.sv | 21 ++
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port DMEM arbiter.
// The default memory size is also used to size the data memory itself.
package dmem_arbiter_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // A word access touches addr..addr+3, so the last legal start is mem_bytes-4.
  // Comparing against that bound keeps addr+3 from ever wrapping.
  function automatic logic addr_is_legal(
    input logic [31:0] addr,
    input logic [31:0] mem_bytes,
    input logic        align_check
  );
    logic in_range;
    logic aligned;
    in_range = (addr <= (mem_bytes - 32'd4));
    aligned  = !align_check || (addr[1:0] == 2'b00);
    return in_range && aligned;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-requester round-robin picker: a lone requester always wins,
// a tie goes to the port named by the priority pointer.
module dmem_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_rr,
  output logic       o_grant_valid,
  output logic       o_grant_idx
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = 1'b0;
    case (i_req)
      2'b01:   o_grant_idx = 1'b0;
      2'b10:   o_grant_idx = 1'b1;
      2'b11:   o_grant_idx = i_rr;
      default: o_grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer placing one word access at a time on the
// single-ported DMEM, with all DMEM controls registered for a full cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = MEM_BYTES_DEFAULT,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  logic        r_owner;
  logic        w_owner_next;
  logic        r_rr;
  logic        w_rr_next;
  logic        r_lat_we;
  logic        w_lat_we_next;
  logic [1:0]  r_done;
  logic [1:0]  w_done_next;
  logic [1:0]  r_err;
  logic [1:0]  w_err_next;
  logic [31:0] r_p0_rdata;
  logic [31:0] w_p0_rdata_next;
  logic [31:0] r_p1_rdata;
  logic [31:0] w_p1_rdata_next;
  logic [31:0] r_dmem_addr;
  logic [31:0] w_dmem_addr_next;
  logic [31:0] r_dmem_wdata;
  logic [31:0] w_dmem_wdata_next;
  logic        r_mem_write;
  logic        w_mem_write_next;
  logic        r_mem_read;
  logic        w_mem_read_next;

  logic        w_grant_valid;
  logic        w_grant_idx;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_legal;

  dmem_rr_pick u_pick (
    .i_req         ({p1_req, p0_req}),
    .i_rr          (r_rr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_sel_we    = w_grant_idx ? p1_we    : p0_we;
  assign w_sel_addr  = w_grant_idx ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_grant_idx ? p1_wdata : p0_wdata;
  assign w_sel_legal = addr_is_legal(w_sel_addr, 32'(MEM_BYTES), ALIGN_CHECK);

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_rr_next         = r_rr;
    w_lat_we_next     = r_lat_we;
    w_done_next       = 2'b00;
    w_err_next        = 2'b00;
    w_p0_rdata_next   = r_p0_rdata;
    w_p1_rdata_next   = r_p1_rdata;
    w_dmem_addr_next  = r_dmem_addr;
    w_dmem_wdata_next = r_dmem_wdata;
    w_mem_write_next  = 1'b0;
    w_mem_read_next   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_owner_next  = w_grant_idx;
          w_lat_we_next = w_sel_we;
          // Owner's rdata reads back as zero for writes and rejected accesses.
          if (w_grant_idx) begin
            w_p1_rdata_next = 32'd0;
          end else begin
            w_p0_rdata_next = 32'd0;
          end
          if (w_sel_legal) begin
            w_state_next      = ST_ACCESS;
            w_dmem_addr_next  = w_sel_addr;
            w_dmem_wdata_next = w_sel_wdata;
            w_mem_write_next  = w_sel_we;
            w_mem_read_next   = !w_sel_we;
          end else begin
            w_state_next             = ST_RESP;
            w_done_next[w_grant_idx] = 1'b1;
            w_err_next[w_grant_idx]  = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        if (!r_lat_we) begin
          if (r_owner) begin
            w_p1_rdata_next = DMEM_data_out;
          end else begin
            w_p0_rdata_next = DMEM_data_out;
          end
        end
        w_done_next[r_owner] = 1'b1;
        w_state_next         = ST_RESP;
      end

      ST_RESP: begin
        w_rr_next    = ~r_owner;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_rr         <= 1'b0;
      r_lat_we     <= 1'b0;
      r_done       <= 2'b00;
      r_err        <= 2'b00;
      r_p0_rdata   <= 32'd0;
      r_p1_rdata   <= 32'd0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_rr         <= w_rr_next;
      r_lat_we     <= w_lat_we_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_p0_rdata   <= w_p0_rdata_next;
      r_p1_rdata   <= w_p1_rdata_next;
      r_dmem_addr  <= w_dmem_addr_next;
      r_dmem_wdata <= w_dmem_wdata_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_read   <= w_mem_read_next;
    end
  end

  assign p0_done        = r_done[0];
  assign p1_done        = r_done[1];
  assign p0_err         = r_err[0];
  assign p1_err         = r_err[1];
  assign p0_rdata       = r_p0_rdata;
  assign p1_rdata       = r_p1_rdata;
  assign DMEM_address   = r_dmem_addr;
  assign DMEM_data_in   = r_dmem_wdata;
  assign DMEM_mem_write = r_mem_write;
  assign DMEM_mem_read  = r_mem_read;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian 256-byte DMEM model
// (negedge write, combinational read) attached to the DMEM port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(256), .ALIGN_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_done        (p0_done),
    .p0_err         (p0_err),
    .p0_rdata       (p0_rdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_done        (p1_done),
    .p1_err         (p1_err),
    .p1_rdata       (p1_rdata),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_data_out  (DMEM_data_out)
  );

  // DMEM model
  logic [7:0] mem [0:255];
  logic [7:0] w_a;
  assign w_a = DMEM_address[7:0];
  assign DMEM_data_out = {mem[w_a], mem[w_a + 8'd1], mem[w_a + 8'd2], mem[w_a + 8'd3]};

  always @(negedge clk) begin
    if (DMEM_mem_write) begin
      mem[w_a]        = DMEM_data_in[31:24];
      mem[w_a + 8'd1] = DMEM_data_in[23:16];
      mem[w_a + 8'd2] = DMEM_data_in[15:8];
      mem[w_a + 8'd3] = DMEM_data_in[7:0];
    end
  end

  // Read and write strobes must never be asserted together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if (DMEM_mem_write && DMEM_mem_read) begin
        n_bad++;
        $display("FAIL strobe_excl: write=%0b read=%0b required not both 1", DMEM_mem_write, DMEM_mem_read);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  function automatic logic pdone(input bit p);
    return p ? p1_done : p0_done;
  endfunction

  // Count posedges until port p shows done; 99 means it never came.
  task automatic wait_done(input bit p, output int lat, output bit other_done);
    bit got;
    got = 1'b0;
    lat = 0;
    other_done = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (pdone(!p)) other_done = 1'b1;
      if (pdone(p)) got = 1'b1;
    end
    if (!got) lat = 99;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  task automatic do_access(input vec_t v);
    logic [31:0] other_hold;
    int          lat;
    bit          seen_w, seen_r, other_done;
    bit          got;
    @(posedge clk); #1;
    other_hold = v.port ? p0_rdata : p1_rdata;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    lat = 0; got = 1'b0; seen_w = 1'b0; seen_r = 1'b0; other_done = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      seen_w |= DMEM_mem_write;
      seen_r |= DMEM_mem_read;
      if (pdone(!v.port)) other_done = 1'b1;
      if (pdone(v.port)) got = 1'b1;
    end
    if (!got) lat = 99;
    $display("txn %s port=%0d we=%0b addr=%h lat=%0d err=%0b rdata=%h",
             v.name, v.port, v.we, v.addr, lat, v.port ? p1_err : p0_err, v.port ? p1_rdata : p0_rdata);
    check({v.name, "_latency"}, lat, v.exp_err ? 1 : 2);
    check({v.name, "_err"}, v.port ? p1_err : p0_err, v.exp_err);
    check({v.name, "_rdata"}, v.port ? p1_rdata : p0_rdata, v.exp_rdata);
    check({v.name, "_wstrobe"}, seen_w, !v.exp_err && v.we);
    check({v.name, "_rstrobe"}, seen_r, !v.exp_err && !v.we);
    check({v.name, "_resp_strobes"}, {DMEM_mem_write, DMEM_mem_read}, 2'b00);
    check({v.name, "_other_done"}, other_done, 1'b0);
    drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check({v.name, "_done_pulse"}, pdone(v.port), 1'b0);
    check({v.name, "_other_rdata_hold"}, v.port ? p0_rdata : p1_rdata, other_hold);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    bit   od;
    vec_t v;
    logic [9:0] done_mask;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0]  = '{1'b0, 1'b1, 32'd8,          32'hDEADBEEF, 1'b0, 32'h0,        "wr8"};
    vecs[1]  = '{1'b0, 1'b0, 32'd8,          32'h0,        1'b0, 32'hDEADBEEF, "rd8"};
    vecs[2]  = '{1'b1, 1'b0, 32'd6,          32'h0,        1'b1, 32'h0,        "mis6"};
    vecs[3]  = '{1'b1, 1'b0, 32'd253,        32'h0,        1'b1, 32'h0,        "oor253"};
    vecs[4]  = '{1'b0, 1'b1, 32'd252,        32'h01020304, 1'b0, 32'h0,        "wr252"};
    vecs[5]  = '{1'b0, 1'b0, 32'd252,        32'h0,        1'b0, 32'h01020304, "rd252"};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,          32'h0,        1'b0, 32'h0,        "rd0"};
    vecs[7]  = '{1'b1, 1'b1, 32'hFFFFFFFC,   32'h55555555, 1'b1, 32'h0,        "oorFFFC"};
    vecs[8]  = '{1'b1, 1'b0, 32'd8,          32'h0,        1'b0, 32'hDEADBEEF, "p1rd8"};
    vecs[9]  = '{1'b1, 1'b1, 32'd4,          32'hCAFEF00D, 1'b0, 32'h0,        "p1wr4"};
    vecs[10] = '{1'b0, 1'b0, 32'd4,          32'h0,        1'b0, 32'hCAFEF00D, "rd4"};
    vecs[11] = '{1'b0, 1'b0, 32'd2,          32'h0,        1'b1, 32'h0,        "mis2"};
    vecs[12] = '{1'b0, 1'b1, 32'd256,        32'h77777777, 1'b1, 32'h0,        "oor256"};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {p0_done, p0_err, p1_done, p1_err, DMEM_mem_write, DMEM_mem_read}, 6'b0);
    check("reset_p0_rdata", p0_rdata, 32'h0);
    check("reset_p1_rdata", p1_rdata, 32'h0);
    check("reset_dmem_addr", DMEM_address, 32'h0);
    check("reset_dmem_din", DMEM_data_in, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) do_access(vecs[i]);

    check("bytes_8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);
    check("bytes_252_255", {mem[252], mem[253], mem[254], mem[255]}, 32'h01020304);
    check("bytes_0_3", {mem[0], mem[1], mem[2], mem[3]}, 32'h0);

    // Contention straight after reset: rr=0 so p0 wins, p1 follows.
    apply_reset();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'd16, 32'h11111111);
    drive(1'b1, 1'b1, 1'b1, 32'd20, 32'h22222222);
    wait_done(1'b0, lat, od);
    $display("txn pair1_p0 lat=%0d p1_done_seen=%0b", lat, od);
    check("pair1_p0_latency", lat, 2);
    check("pair1_p0_first", od, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_done(1'b1, lat, od);
    $display("txn pair1_p1 lat=%0d p0_done_seen=%0b", lat, od);
    check("pair1_p1_wait", lat, 3);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    // After p0 is served alone the pointer favours p1.
    v = '{1'b0, 1'b0, 32'd16, 32'h0, 1'b0, 32'h11111111, "rd16"};
    do_access(v);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'd16, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd20, 32'd0);
    wait_done(1'b1, lat, od);
    $display("txn pair2_p1 lat=%0d p0_done_seen=%0b rdata=%h", lat, od, p1_rdata);
    check("pair2_p1_latency", lat, 2);
    check("pair2_p1_first", od, 1'b0);
    check("pair2_p1_rdata", p1_rdata, 32'h22222222);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_done(1'b0, lat, od);
    $display("txn pair2_p0 lat=%0d rdata=%h", lat, p0_rdata);
    check("pair2_p0_wait", lat, 3);
    check("pair2_p0_rdata", p0_rdata, 32'h11111111);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset asserted during the ACCESS cycle of a write.
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'd40, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("rstmid_in_access", DMEM_mem_write, 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    $display("txn rst_mid_access done=%0b wr=%0b addr=%h", p0_done, DMEM_mem_write, DMEM_address);
    check("rstmid_flags", {p0_done, p0_err, p1_done, p1_err, DMEM_mem_write, DMEM_mem_read}, 6'b0);
    check("rstmid_dmem_addr", DMEM_address, 32'h0);
    check("rstmid_dmem_din", DMEM_data_in, 32'h0);
    check("rstmid_p1_rdata", p1_rdata, 32'h0);
    @(posedge clk); #1;
    check("rstmid_no_done", {p0_done, p1_done}, 2'b00);
    rst_n = 1'b1;
    v = '{1'b0, 1'b0, 32'd252, 32'h0, 1'b0, 32'h01020304, "post_rst_rd"};
    do_access(v);

    // p1 holds req for 9 cycles: dones after edges 2, 5 and 8.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'd252, 32'd0);
    done_mask = '0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (p1_done) done_mask[k] = 1'b1;
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    $display("txn b2b done_mask=%b rdata=%h", done_mask, p1_rdata);
    check("b2b_done_spacing", done_mask, 10'h124);
    check("b2b_rdata", p1_rdata, 32'h01020304);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_no_extra", p1_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
